// File: rtl/serial_pattern_gen_if.sv
// Handshake and serial-output bundle for serial_pattern_gen.
// The master side requests jobs, and the slave side (the generator) drives the stream.
interface serial_pattern_gen_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps,
    input  out, out_valid, busy, done
  );

  modport slave (
    input  start, pattern, reps,
    output out, out_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_gen.sv
// Moore serial pattern transmitter. It shifts a captured pattern out MSB first,
// repeats it reps times with GAP_CYC idle cycles between repetitions, and then pulses done.
module serial_pattern_gen #(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  serial_pattern_gen_if.slave bus
);

  localparam int BW = $clog2(PAT_W);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [PAT_W-1:0] shadow_q, shadow_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      shadow_q <= '0;
      bit_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      bit_q    <= bit_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    bit_d    = bit_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shadow_d = bus.pattern;
          shift_d  = bus.pattern;
          rep_d    = (bus.reps == '0) ? CNT_W'(1) : bus.reps;
          bit_d    = BIT_LAST;
          state_d  = SEND;
        end
      end
      SEND: begin
        shift_d = shift_q << 1;
        bit_d   = bit_q - 1'b1;
        if (bit_q == '0) begin
          rep_d = rep_q - 1'b1;
          if (rep_q == CNT_W'(1)) begin
            state_d = DONE;
          end else if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = GAP_LAST;
          end else begin
            // With no gap, the next repetition's first bit directly follows the last bit.
            shift_d = shadow_q;
            bit_d   = BIT_LAST;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          shift_d = shadow_q;
          bit_d   = BIT_LAST;
          state_d = SEND;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.out       = (state_q == SEND) & shift_q[PAT_W-1];
  assign bus.out_valid = (state_q == SEND);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
Moore-style serial pattern transmitter. It is the sending end for the team's serial sequence detectors.
- Captures a parallel PAT_W-bit pattern and a repeat count on a start request.
- Shifts the pattern out MSB first, one bit per clock, repeating it the requested number of times with a programmable idle gap between repetitions.
- Drives stimulus into, or loops back to, the 101-style detector blocks.

Parameters:
PAT_W, 8, pattern width in bits (>=2)
CNT_W, 4, width of repeat-count input
GAP_CYC, 2, idle cycles inserted between repetitions (0 = back-to-back)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request to begin transmission; sampled only in IDLE
pattern  input  PAT_W  bit pattern to send, captured when start is accepted
reps  input  CNT_W  number of repetitions, captured with pattern; 0 treated as 1
out  output  1  serial data bit
out_valid  output  1  high when out carries a pattern bit
busy  output  1  high from the cycle after start acceptance through the DONE cycle
done  output  1  one-cycle pulse when the final repetition completes

Behaviour:
- Reset (rst=0, async, regardless of clk):
  - state=IDLE.
  - out=0, out_valid=0, busy=0, done=0.
  - Shift register, shadow pattern, bit counter and rep counter cleared.
  - Takes effect immediately mid-operation; the transmission is abandoned, not resumed.
- Moore FSM. All outputs are a function of registered state only; no combinational path from inputs to outputs.
- States: IDLE, SEND, GAP, DONE.
- IDLE: outputs 0. If start=1 at a rising edge:
  - shadow <= pattern; shift <= pattern.
  - rep_cnt <= (reps==0 ? 1 : reps).
  - bit_cnt <= PAT_W-1.
  - go to SEND.
- SEND:
  - out = shift[PAT_W-1], out_valid=1, busy=1.
  - Each edge: shift <= shift<<1, bit_cnt decrements.
  - When bit_cnt==0 at the edge, rep_cnt decrements. Then:
    - if rep_cnt was 1, go to DONE;
    - else if GAP_CYC>0, go to GAP with gap_cnt <= GAP_CYC-1;
    - else reload shift from shadow, bit_cnt <= PAT_W-1, stay in SEND (no bubble).
- GAP:
  - out=0, out_valid=0, busy=1.
  - Lasts exactly GAP_CYC cycles.
  - On the last cycle, reload shift from shadow, bit_cnt <= PAT_W-1, go to SEND.
- DONE: done=1, busy=1, out=0, out_valid=0, for one cycle; then IDLE unconditionally.
- Latency: start accepted at edge k, so the first bit is visible in the cycle after edge k.
- Total busy cycles = reps*PAT_W + (reps-1)*GAP_CYC + 1.
- start in SEND, GAP or DONE is ignored. pattern and reps changes while busy have no effect (shadow copy is used).
- start held high continuously: a new transmission is accepted on the first edge in IDLE, i.e. one idle cycle between jobs.
- Counters are sized to hold PAT_W-1, GAP_CYC-1 and 2^CNT_W-1 without wrap. reps = all-ones is legal.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with start=1 -> out, out_valid, busy, done all 0; no transmission begins.
2. Single shot: pattern=8'hA5, reps=1, one-cycle start -> out = 1,0,1,0,0,1,0,1 on the 8 cycles after the accepting edge, out_valid high for exactly those 8 cycles; done=1 in cycle 9; busy high cycles 1-9; IDLE in cycle 10.
3. Repeat with gap: pattern=8'hB0, reps=2, GAP_CYC=2 -> cycles 1-8 send 1,0,1,1,0,0,0,0; cycles 9-10 out_valid=0; cycles 11-18 repeat the same bits; done in cycle 19.
4. reps=0 and back-to-back: reps=0 sends exactly one pattern. With GAP_CYC=0 and reps=3 -> 24 contiguous valid bits; done in cycle 25.
5. Ignored start and input change: assert start and change pattern to 8'hFF in cycle 4 of a pattern=8'h5A job -> output stream stays 0,1,0,1,1,0,1,0; no second job starts.
6. Reset mid-operation: drive rst=0 asynchronously between edges during cycle 5 -> outputs go to 0 before the next edge; after release, a new start with pattern=8'h81 sends 1,0,0,0,0,0,0,1 cleanly, with no leftover bits from the aborted job.
